// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the write-back stage.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Write-back bus: ALU result, long-latency result, issue notification,
// register-file write port, scoreboard and FIFO occupancy.
// master = producers/consumers around the stage, slave = reg_writeback.
interface reg_writeback_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                     AluValid;
    logic                     AluReady;
    logic [ADDR_W-1:0]        AluRd;
    logic [DATA_W-1:0]        AluData;

    logic                     LdValid;
    logic                     LdReady;
    logic [ADDR_W-1:0]        LdRd;
    logic [DATA_W-1:0]        LdData;

    logic                     IssueValid;
    logic [ADDR_W-1:0]        IssueRd;

    logic [ADDR_W-1:0]        RD;
    logic [DATA_W-1:0]        WData;
    logic                     RegWr;
    logic [31:0]              Busy;
    logic [$clog2(DEPTH):0]   FifoCount;

    modport master (
        output AluValid, AluRd, AluData,
        output LdValid, LdRd, LdData,
        output IssueValid, IssueRd,
        input  AluReady, LdReady,
        input  RD, WData, RegWr, Busy, FifoCount
    );

    modport slave (
        input  AluValid, AluRd, AluData,
        input  LdValid, LdRd, LdData,
        input  IssueValid, IssueRd,
        output AluReady, LdReady,
        output RD, WData, RegWr, Busy, FifoCount
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding {rd, data} for long-latency results.
// DEPTH must be a power of two so the pointers wrap naturally.
// Callers never push when full or pop when empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter: sole writer of the 32x32 register file.
// Picks one of ALU / long-latency FIFO each cycle, registers the write port
// and keeps the busy-register scoreboard for the hazard logic.
// Optional macro WB_TRACE_EN adds a simulation-only write trace.
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    reg_writeback_if.slave wb
);
    import cpu_pkg::*;

    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0]          head;
    logic [ADDR_W-1:0]      head_rd;
    logic [DATA_W-1:0]      head_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    wb_src_t                sel;
    logic [ADDR_W-1:0]      sel_rd;
    logic [DATA_W-1:0]      sel_data;

    logic [ADDR_W-1:0]      rd_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   regwr_q;
    logic [31:0]            busy_q;
    logic [31:0]            busy_nxt;

    assign push = wb.LdValid && !fifo_full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .wdata ({wb.LdRd, wb.LdData}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_rd   = head[EW-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    // Source select: a full FIFO must drain first, otherwise ALU has priority.
    always_comb begin
        sel      = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (fifo_full) begin
            sel      = WB_LD;
            sel_rd   = head_rd;
            sel_data = head_data;
        end else if (wb.AluValid) begin
            sel      = WB_ALU;
            sel_rd   = wb.AluRd;
            sel_data = wb.AluData;
        end else if (!fifo_empty) begin
            sel      = WB_LD;
            sel_rd   = head_rd;
            sel_data = head_data;
        end
    end

    assign pop = (sel == WB_LD);

    // Scoreboard update: clear on pop of the head, then set on issue so set wins.
    always_comb begin
        busy_nxt = busy_q;
        if (pop) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (wb.IssueValid && (wb.IssueRd != REG_ZERO)) begin
            busy_nxt[wb.IssueRd] = 1'b1;
        end
    end

    // Registered write port and scoreboard; r0 writes are consumed silently.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q    <= '0;
            wdata_q <= '0;
            regwr_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (sel != WB_NONE) begin
                rd_q    <= sel_rd;
                wdata_q <= sel_data;
                regwr_q <= (sel_rd != REG_ZERO);
            end else begin
                regwr_q <= 1'b0;
            end
        end
    end

    assign wb.AluReady  = !fifo_full;
    assign wb.LdReady   = !fifo_full;
    assign wb.RD        = rd_q;
    assign wb.WData     = wdata_q;
    assign wb.RegWr     = regwr_q;
    assign wb.Busy      = busy_q;
    assign wb.FifoCount = fifo_count;

`ifdef WB_TRACE_EN
    wb_src_t src_q;

    // Remember which source produced the registered write for the trace.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) src_q <= WB_NONE;
        else       src_q <= sel;
    end

    // Trace each committed write and the moment the FIFO becomes full.
    always @(posedge Clk) begin
        if (!Reset && regwr_q) begin
            $display("%0t wb %s rd=%h data=%h", $time,
                     (src_q == WB_ALU) ? "ALU" : "LD", rd_q, wdata_q);
        end
        if (!Reset && push && !pop && (fifo_count == ($clog2(DEPTH)+1)'(DEPTH - 1))) begin
            $display("%0t wb fifo full", $time);
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed test of the write-back arbiter with hand-computed expectations.
module tb_reg_writeback;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic Clk;
    logic Reset;

    int n_checks;
    int n_errors;

    reg_writeback_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_writeback #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.AluValid   = 1'b0;
        bus.AluRd      = '0;
        bus.AluData    = '0;
        bus.LdValid    = 1'b0;
        bus.LdRd       = '0;
        bus.LdData     = '0;
        bus.IssueValid = 1'b0;
        bus.IssueRd    = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        idle_inputs();

        // Reset state
        #2;
        chk("rst_regwr", 32'(bus.RegWr), 32'd0);
        chk("rst_rd", 32'(bus.RD), 32'd0);
        chk("rst_wdata", bus.WData, 32'd0);
        chk("rst_busy", bus.Busy, 32'd0);
        chk("rst_count", 32'(bus.FifoCount), 32'd0);
        chk("rst_ldready", 32'(bus.LdReady), 32'd1);
        step();
        step();
        Reset = 1'b0;

        // Single ALU write
        bus.AluValid = 1'b1; bus.AluRd = 5'd3; bus.AluData = 32'h1234;
        #1;
        chk("alu_ready", 32'(bus.AluReady), 32'd1);
        step();
        idle_inputs();
        chk("alu_rd", 32'(bus.RD), 32'd3);
        chk("alu_wdata", bus.WData, 32'h1234);
        chk("alu_regwr", 32'(bus.RegWr), 32'd1);
        step();
        chk("alu_regwr_off", 32'(bus.RegWr), 32'd0);

        // Issue then load to r5
        bus.IssueValid = 1'b1; bus.IssueRd = 5'd5;
        step();
        idle_inputs();
        chk("issue_busy5", bus.Busy, 32'h0000_0020);
        bus.LdValid = 1'b1; bus.LdRd = 5'd5; bus.LdData = 32'hDEAD;
        step();
        idle_inputs();
        chk("ld_push_count", 32'(bus.FifoCount), 32'd1);
        chk("ld_push_regwr", 32'(bus.RegWr), 32'd0);
        chk("ld_push_busy", bus.Busy, 32'h0000_0020);
        step();
        chk("ld_pop_count", 32'(bus.FifoCount), 32'd0);
        chk("ld_pop_regwr", 32'(bus.RegWr), 32'd1);
        chk("ld_pop_rd", 32'(bus.RD), 32'd5);
        chk("ld_pop_wdata", bus.WData, 32'hDEAD);
        chk("ld_pop_busy", bus.Busy, 32'd0);
        step();
        chk("idle_regwr", 32'(bus.RegWr), 32'd0);

        // Fill FIFO with rd 6..9 while ALU (rd 20) holds priority
        bus.AluValid = 1'b1; bus.AluRd = 5'd20; bus.AluData = 32'h0000_00A0;
        for (int i = 0; i < 4; i++) begin
            bus.LdValid = 1'b1;
            bus.LdRd    = 5'(6 + i);
            bus.LdData  = 32'h600 + 32'(i * 256);
            step();
            chk("fill_alu_rd", 32'(bus.RD), 32'd20);
            chk("fill_count", 32'(bus.FifoCount), 32'(i + 1));
        end
        bus.LdValid = 1'b0;
        chk("full_ldready", 32'(bus.LdReady), 32'd0);
        chk("full_aluready", 32'(bus.AluReady), 32'd0);
        step();
        chk("drain6_rd", 32'(bus.RD), 32'd6);
        chk("drain6_wdata", bus.WData, 32'h600);
        chk("drain6_count", 32'(bus.FifoCount), 32'd3);
        chk("drain6_aluready", 32'(bus.AluReady), 32'd1);
        step();
        chk("interleave_rd", 32'(bus.RD), 32'd20);
        chk("interleave_count", 32'(bus.FifoCount), 32'd3);
        bus.AluValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("drain_rd", 32'(bus.RD), 32'(6 + i));
            chk("drain_wdata", bus.WData, 32'h600 + 32'(i * 256));
            chk("drain_regwr", 32'(bus.RegWr), 32'd1);
        end
        chk("drain_count", 32'(bus.FifoCount), 32'd0);
        step();
        chk("drain_idle", 32'(bus.RegWr), 32'd0);

        // Writes to r0 are consumed without RegWr
        bus.AluValid = 1'b1; bus.AluRd = 5'd0; bus.AluData = 32'hFFFF;
        #1;
        chk("r0_aluready", 32'(bus.AluReady), 32'd1);
        step();
        idle_inputs();
        chk("r0_alu_regwr", 32'(bus.RegWr), 32'd0);
        chk("r0_alu_wdata", bus.WData, 32'hFFFF);
        bus.LdValid = 1'b1; bus.LdRd = 5'd0; bus.LdData = 32'hBEEF;
        step();
        idle_inputs();
        chk("r0_ld_count", 32'(bus.FifoCount), 32'd1);
        step();
        chk("r0_ld_pop_count", 32'(bus.FifoCount), 32'd0);
        chk("r0_ld_regwr", 32'(bus.RegWr), 32'd0);
        chk("r0_ld_wdata", bus.WData, 32'hBEEF);

        // Set wins over clear on the same register
        bus.IssueValid = 1'b1; bus.IssueRd = 5'd7;
        step();
        idle_inputs();
        chk("busy7_set", bus.Busy, 32'h0000_0080);
        bus.LdValid = 1'b1; bus.LdRd = 5'd7; bus.LdData = 32'h77;
        step();
        idle_inputs();
        bus.IssueValid = 1'b1; bus.IssueRd = 5'd7;
        step();
        idle_inputs();
        chk("setwin_rd", 32'(bus.RD), 32'd7);
        chk("setwin_regwr", 32'(bus.RegWr), 32'd1);
        chk("setwin_busy", bus.Busy, 32'h0000_0080);

        // Async reset with 3 queued entries and Busy = 0x1C0
        bus.IssueValid = 1'b1; bus.IssueRd = 5'd6;
        step();
        bus.IssueRd = 5'd8;
        step();
        bus.IssueValid = 1'b0;
        chk("pre_rst_busy", bus.Busy, 32'h0000_01C0);
        bus.AluValid = 1'b1; bus.AluRd = 5'd21; bus.AluData = 32'h2121;
        for (int i = 0; i < 3; i++) begin
            bus.LdValid = 1'b1;
            bus.LdRd    = 5'(6 + i);
            bus.LdData  = 32'hC00 + 32'(i);
            step();
        end
        bus.LdValid = 1'b0;
        chk("pre_rst_count", 32'(bus.FifoCount), 32'd3);
        chk("pre_rst_regwr", 32'(bus.RegWr), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_regwr", 32'(bus.RegWr), 32'd0);
        chk("async_count", 32'(bus.FifoCount), 32'd0);
        chk("async_busy", bus.Busy, 32'd0);
        idle_inputs();
        step();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_regwr", 32'(bus.RegWr), 32'd0);
            chk("post_rst_count", 32'(bus.FifoCount), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
